// File: rtl/freq_window_monitor_if.sv
// intbus_interf: word-addressed internal register bus with one-cycle read latency
interface intbus_interf (input logic clk);
  logic [15:0] addr;
  logic        wr, rd;
  logic [31:0] wdata, rdata;
  logic        rvalid;
  modport master (input clk, rdata, rvalid, output addr, wr, rd, wdata);
  modport slave (input addr, wr, rd, wdata, output rdata, rvalid);
endinterface

// File: rtl/freq_window_monitor.sv
// freq_window_monitor: per-channel [LO,HI] frequency window checker with debounce, sticky alarms and irq
module freq_window_monitor #(
  parameter int BASEADDR    = 0,
  parameter int CHANNELS    = 1,
  parameter int DATA_W      = 24,
  parameter int FAIL_CNT    = 3,
  parameter int OK_CNT      = 3,
  parameter int TIMEOUT_CYC = 2**24
) (
  input  logic                      clk,
  input  logic                      resetn,
  intbus_interf.slave               bus,
  input  logic                      meas_valid,
  input  logic [$clog2(CHANNELS):0] meas_chan,
  input  logic [DATA_W-1:0]         meas_data,
  output logic                      irq
);
  localparam int CW = $clog2(CHANNELS) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int NREG = 5 + 2 * CHANNELS;
  localparam logic [15:0] BASE = 16'(BASEADDR);
  localparam logic [31:0] MASK = 32'h8000_0000 | ((32'h1 << CHANNELS) - 32'h1);
  localparam logic [31:0] ID = 32'((5 + 2 * CHANNELS) << 16) | 32'h1C41;

  typedef enum logic [1:0] {IDLE, OK, FAIL} state_t;

  logic [23:0]         lo [CHANNELS];
  logic [23:0]         hi [CHANNELS];
  logic [23:0]         d;
  logic [CHANNELS-1:0] fail_v, enter;
  logic [TW-1:0]       scnt;
  logic                stale, stale_hit, stale_set, mapped, wr_en;
  logic [15:0]         off;
  logic [31:0]         alarm, irq_en, status, w1c, set_v, rd_val;

  assign d         = 24'(meas_data);
  assign off       = bus.addr - BASE;
  assign mapped    = bus.addr >= BASE && off < 16'(NREG);
  assign wr_en     = bus.wr && mapped;
  assign w1c       = wr_en && off == 16'd3 ? bus.wdata : '0;
  assign stale_hit = scnt == TW'(TIMEOUT_CYC - 1);
  assign stale_set = !meas_valid && stale_hit && !stale;
  assign status    = {stale, 31'(fail_v)};
  assign set_v     = {stale_set, 31'(enter)};

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t     st;
    logic [3:0] dcnt, inc;
    logic       in_win, hit;
    assign in_win     = lo[c] <= d && d <= hi[c];
    assign hit        = meas_valid && meas_chan == CW'(c);
    assign inc        = dcnt == 4'd15 ? 4'd15 : dcnt + 4'd1;
    assign enter[c]   = hit && st != FAIL && !in_win && inc == 4'(FAIL_CNT);
    assign fail_v[c]  = st == FAIL;
    always_ff @(posedge clk) begin
      if (!resetn) begin
        st   <= IDLE;
        dcnt <= '0;
      end else if (hit) begin
        if (st == FAIL) begin
          st   <= in_win && inc == 4'(OK_CNT) ? OK : FAIL;
          dcnt <= in_win && inc != 4'(OK_CNT) ? inc : 4'd0;
        end else if (in_win) begin
          st   <= OK;
          dcnt <= '0;
        end else begin
          st   <= enter[c] ? FAIL : st;
          dcnt <= enter[c] ? 4'd0 : inc;
        end
      end
    end
  end

  always_comb begin
    rd_val = off == 16'd0 ? ID : off == 16'd1 ? 32'(CHANNELS) : off == 16'd2 ? status :
             off == 16'd3 ? alarm : off == 16'd4 ? irq_en : '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (off == 16'(5 + 2 * i)) rd_val = 32'(lo[i]);
      if (off == 16'(6 + 2 * i)) rd_val = 32'(hi[i]);
    end
  end

  // alarm sets take priority over a coincident W1C of the same bit
  always_ff @(posedge clk) begin
    if (!resetn) begin
      scnt       <= '0;
      stale      <= 1'b0;
      alarm      <= '0;
      irq_en     <= '0;
      irq        <= 1'b0;
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        lo[i] <= '0;
        hi[i] <= '1;
      end
    end else begin
      scnt       <= meas_valid ? '0 : stale_hit ? scnt : scnt + 1'b1;
      stale      <= meas_valid ? 1'b0 : stale | stale_hit;
      alarm      <= ((alarm & ~w1c) | set_v) & MASK;
      irq_en     <= wr_en && off == 16'd4 ? bus.wdata & MASK : irq_en;
      irq        <= |(alarm & irq_en);
      bus.rvalid <= bus.rd && mapped;
      bus.rdata  <= bus.rd && mapped ? rd_val : '0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_en && off == 16'(5 + 2 * i)) lo[i] <= bus.wdata[23:0];
        if (wr_en && off == 16'(6 + 2 * i)) hi[i] <= bus.wdata[23:0];
      end
    end
  end
endmodule

// File: tb/tb_freq_window_monitor.sv
// tb_freq_window_monitor: directed plus randomized checks against a behavioural register/FSM model
module tb_freq_window_monitor;
  localparam int CH = 4, FC = 3, OC = 3, TO = 64, NREG = 5 + 2 * CH;
  localparam int S_IDLE = 0, S_OK = 1, S_FAIL = 2;
  localparam logic [31:0] MASK = 32'h8000_000F;

  logic        clk = 0, resetn = 0, meas_valid = 0, irq;
  logic [2:0]  meas_chan = 0;
  logic [23:0] meas_data = 0;
  int          total = 0, bad = 0;
  bit          chk_en = 0;

  logic [23:0] m_lo [CH];
  logic [23:0] m_hi [CH];
  int          m_st [CH];
  int          m_d [CH];
  int          m_idle;
  logic [31:0] m_alarm, m_ien, m_rdata;
  logic        m_rvalid, m_irq;

  intbus_interf bus (.clk(clk));

  freq_window_monitor #(.BASEADDR(0), .CHANNELS(CH), .DATA_W(24), .FAIL_CNT(FC), .OK_CNT(OC),
                        .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .meas_valid(meas_valid), .meas_chan(meas_chan),
    .meas_data(meas_data), .irq(irq));

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_val(int off);
    logic [31:0] s;
    s = '0;
    if (off == 0) return 32'(((5 + 2 * CH) << 16) | 'h1C41);
    if (off == 1) return 32'(CH);
    if (off == 2) begin
      for (int i = 0; i < CH; i++) s[i] = m_st[i] == S_FAIL;
      s[31] = m_idle >= TO;
      return s;
    end
    if (off == 3) return m_alarm;
    if (off == 4) return m_ien;
    return (off - 5) % 2 == 0 ? 32'(m_lo[(off - 5) / 2]) : 32'(m_hi[(off - 5) / 2]);
  endfunction

  task automatic model_step();
    int off, c;
    logic in_w;
    logic [31:0] setv, w1c;
    if (!resetn) begin
      for (int i = 0; i < CH; i++) begin
        m_lo[i] = 0; m_hi[i] = 24'hFFFFFF; m_st[i] = S_IDLE; m_d[i] = 0;
      end
      m_idle = 0; m_alarm = 0; m_ien = 0; m_rdata = 0; m_rvalid = 0; m_irq = 0;
      return;
    end
    off = int'(bus.addr);
    m_rvalid = bus.rd && off < NREG;
    m_rdata = m_rvalid ? reg_val(off) : 32'h0;
    m_irq = |(m_alarm & m_ien);
    setv = 0;
    w1c = 0;
    if (meas_valid) begin
      m_idle = 0;
      c = int'(meas_chan);
      if (c < CH) begin
        in_w = m_lo[c] <= meas_data && meas_data <= m_hi[c];
        if (m_st[c] == S_FAIL) begin
          m_d[c] = in_w ? m_d[c] + 1 : 0;
          if (m_d[c] == OC) begin m_st[c] = S_OK; m_d[c] = 0; end
        end else if (in_w) begin
          m_st[c] = S_OK; m_d[c] = 0;
        end else begin
          m_d[c]++;
          if (m_d[c] == FC) begin m_st[c] = S_FAIL; m_d[c] = 0; setv[c] = 1; end
        end
      end
    end else if (m_idle < TO) begin
      m_idle++;
      if (m_idle == TO) setv[31] = 1;
    end
    if (bus.wr && off < NREG) begin
      if (off == 3) w1c = bus.wdata;
      if (off == 4) m_ien = bus.wdata & MASK;
      if (off >= 5) begin
        if ((off - 5) % 2 == 0) m_lo[(off - 5) / 2] = bus.wdata[23:0];
        else m_hi[(off - 5) / 2] = bus.wdata[23:0];
      end
    end
    m_alarm = ((m_alarm & ~w1c) | setv) & MASK;
  endtask

  always @(negedge clk) if (chk_en) begin
    check("irq", 32'(irq), 32'(m_irq));
    check("rvalid", 32'(bus.rvalid), 32'(m_rvalid));
    check("rdata", bus.rdata, m_rdata);
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr_reg(int a, logic [31:0] v);
    bus.addr = 16'(a); bus.wdata = v; bus.wr = 1; tick(); bus.wr = 0;
  endtask

  task automatic rd_reg(int a, output logic [31:0] v);
    bus.addr = 16'(a); bus.rd = 1; tick(); bus.rd = 0; v = bus.rdata;
  endtask

  task automatic chk_rd(string n, int a, logic [31:0] e);
    logic [31:0] v;
    rd_reg(a, v);
    check(n, v, e);
  endtask

  task automatic smp(int c, int v);
    meas_valid = 1; meas_chan = 3'(c); meas_data = 24'(v); tick(); meas_valid = 0;
  endtask

  initial begin
    logic [31:0] v;
    bus.addr = 0; bus.wr = 0; bus.rd = 0; bus.wdata = 0;
    #1;
    tick();
    chk_en = 1;
    tick();
    resetn = 1;
    chk_rd("id", 0, 32'h000D1C41);
    chk_rd("chan", 1, 32'd4);
    chk_rd("status_rst", 2, 0);
    chk_rd("alarm_rst", 3, 0);
    chk_rd("irqen_rst", 4, 0);
    chk_rd("lo0_rst", 5, 0);
    chk_rd("hi0_rst", 6, 32'h00FFFFFF);
    rd_reg(13, v);
    check("unmapped_rdata", v, 0);
    check("unmapped_rvalid", 32'(bus.rvalid), 0);
    wr_reg(5, 1000);
    wr_reg(6, 2000);
    smp(0, 1500); smp(0, 1500);
    chk_rd("status_inwin", 2, 0);
    smp(0, 2001); smp(0, 2001); smp(0, 2001);
    chk_rd("status_fail", 2, 1);
    chk_rd("alarm_fail", 3, 1);
    check("irq_masked", 32'(irq), 0);
    smp(0, 1500); smp(0, 1500); smp(0, 1500);
    chk_rd("status_recover", 2, 0);
    chk_rd("alarm_sticky", 3, 1);
    smp(0, 2001); smp(0, 2001); smp(0, 1500); smp(0, 2001); smp(0, 2001);
    chk_rd("status_debounce", 2, 0);
    smp(0, 2001);
    chk_rd("status_refail", 2, 1);
    smp(0, 1500); smp(0, 1500); smp(0, 1500);
    chk_rd("status_ok2", 2, 0);
    wr_reg(4, 1);
    chk_rd("irqen", 4, 1);
    check("irq_rise", 32'(irq), 1);
    wr_reg(3, 1);
    check("irq_hold_w1c", 32'(irq), 1);
    tick();
    check("irq_drop", 32'(irq), 0);
    smp(0, 2001); smp(0, 2001);
    meas_valid = 1; meas_chan = 0; meas_data = 2001;
    bus.addr = 3; bus.wdata = 1; bus.wr = 1;
    tick();
    meas_valid = 0; bus.wr = 0;
    check("irq_lag", 32'(irq), 0);
    chk_rd("alarm_set_wins", 3, 1);
    check("irq_after2", 32'(irq), 1);
    smp(0, 1000); smp(0, 2000); smp(0, 1000);
    chk_rd("status_edges", 2, 0);
    wr_reg(3, 1);
    wr_reg(7, 5);
    wr_reg(8, 4);
    smp(1, 4); smp(1, 5);
    chk_rd("status_inv_pre", 2, 0);
    smp(1, 4);
    chk_rd("status_inv_fail", 2, 2);
    for (int i = 0; i < 5; i++) smp(4, 0);
    chk_rd("status_badchan", 2, 2);
    chk_rd("alarm_badchan", 3, 2);
    smp(7, 0);
    repeat (63) tick();
    chk_rd("stale_early", 2, 2);
    chk_rd("stale_status", 2, 32'h80000002);
    chk_rd("stale_alarm", 3, 32'h80000002);
    smp(2, 77);
    chk_rd("stale_clear", 2, 2);
    chk_rd("stale_sticky", 3, 32'h80000002);
    wr_reg(3, 32'h80000000);
    chk_rd("stale_w1c", 3, 2);
    smp(0, 2001); smp(0, 2001);
    resetn = 0;
    tick();
    resetn = 1;
    check("irq_reset", 32'(irq), 0);
    chk_rd("status_reset", 2, 0);
    chk_rd("alarm_reset", 3, 0);
    chk_rd("irqen_reset", 4, 0);
    chk_rd("lo0_reset", 5, 0);
    chk_rd("hi0_reset", 6, 32'h00FFFFFF);
    chk_rd("lo1_reset", 7, 0);
    wr_reg(5, 1000);
    wr_reg(6, 2000);
    smp(0, 2001);
    chk_rd("status_no_carry", 2, 0);
    for (int n = 0; n < 4000; n++) begin
      int c, cc, k, a;
      if ($urandom_range(0, 599) == 0) repeat (70) tick();
      resetn = $urandom_range(0, 799) != 0;
      meas_valid = 1'($urandom_range(0, 1));
      c = $urandom_range(0, 9) < 8 ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 7));
      cc = c % CH;
      k = $urandom_range(0, 4);
      meas_chan = 3'(c);
      meas_data = k == 0 ? m_lo[cc] : k == 1 ? m_hi[cc] : k == 2 ? m_lo[cc] - 24'd1 :
                  k == 3 ? m_hi[cc] + 24'd1 : 24'($urandom_range(0, 3000));
      bus.wr = $urandom_range(0, 9) < 2;
      bus.rd = $urandom_range(0, 2) == 0;
      a = bus.wr ? int'($urandom_range(3, 12)) : int'($urandom_range(0, 15));
      bus.addr = 16'(a);
      bus.wdata = a >= 5 ? 32'($urandom_range(0, 3000)) : $urandom;
      tick();
      resetn = 1; meas_valid = 0; bus.wr = 0; bus.rd = 0;
    end
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
